// File: rtl/main_fifo_reader.sv
// main_fifo_reader: pops the Main ingress FIFO and steers each
// word by its class bit into VC0 or VC1.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   init                hold in INIT, no pops
//   main_empty          Main FIFO empty (already reflects the
//                       pop being issued this cycle)
//   main_data_in [BW]   Main read data, valid cycle after main_rd
//   main_rd             Main pop strobe
//   vc0/1_almost_full   VC FIFO almost full
//   vc0/1_wr            VC FIFO write strobes
//   vc_data_out [BW]    shared VC write data
//   state [2]           0=RESET 1=INIT 2=IDLE 3=ACTIVE
//   idle                IDLE with nothing in flight
//   vc0/1_cnt [CNT_W]   dispatch counters (DISPATCH_CNT_EN)
//
// Optional feature macro: DISPATCH_CNT_EN adds saturating
// per-VC dispatch counters.
module main_fifo_reader #(
  parameter int BW = 6
`ifdef DISPATCH_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          main_empty,
  input  logic [BW-1:0] main_data_in,
  output logic          main_rd,
  input  logic          vc0_almost_full,
  input  logic          vc1_almost_full,
  output logic          vc0_wr,
  output logic          vc1_wr,
  output logic [BW-1:0] vc_data_out,
  output logic [1:0]    state,
`ifdef DISPATCH_CNT_EN
  output logic [CNT_W-1:0] vc0_cnt,
  output logic [CNT_W-1:0] vc1_cnt,
`endif
  output logic          idle
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_main_rd;
  logic          r_pend;
  logic          r_wr0;
  logic          r_wr1;
  logic [BW-1:0] r_data;
  logic          r_idle;

  logic w_pop_ok;
  logic w_cls;
  logic w_wr0_nxt;
  logic w_wr1_nxt;
  logic w_in_flight;

  // main_empty already accounts for an outstanding pop, so
  // back-to-back pops are safe whenever it reads 0.
  assign w_pop_ok = !main_empty
                  && !vc0_almost_full
                  && !vc1_almost_full;

  // r_pend marks the cycle in which main_data_in is valid.
  assign w_cls     = main_data_in[BW-1];
  assign w_wr0_nxt = r_pend && !w_cls;
  assign w_wr1_nxt = r_pend && w_cls;

  assign w_in_flight = r_main_rd || r_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RESET;
      r_main_rd <= 1'b0;
      r_pend    <= 1'b0;
      r_wr0     <= 1'b0;
      r_wr1     <= 1'b0;
      r_data    <= '0;
      r_idle    <= 1'b0;
    end else begin
      // The pipe always drains, even under init or
      // almost-full: a popped word has a guaranteed slot.
      r_pend <= r_main_rd;
      r_wr0  <= w_wr0_nxt;
      r_wr1  <= w_wr1_nxt;
      if (r_pend) begin
        r_data <= main_data_in;
      end

      if (init) begin
        r_state   <= S_INIT;
        r_main_rd <= 1'b0;
        r_idle    <= 1'b0;
      end else begin
        unique case (r_state)
          S_RESET: begin
            r_state   <= S_INIT;
            r_main_rd <= 1'b0;
            r_idle    <= 1'b0;
          end
          S_INIT: begin
            r_state   <= S_IDLE;
            r_main_rd <= 1'b0;
            r_idle    <= !r_main_rd;
          end
          S_IDLE: begin
            if (w_pop_ok) begin
              r_state   <= S_ACTIVE;
              r_main_rd <= 1'b1;
              r_idle    <= 1'b0;
            end else begin
              r_main_rd <= 1'b0;
              r_idle    <= !r_main_rd;
            end
          end
          S_ACTIVE: begin
            r_main_rd <= w_pop_ok;
            if (!w_pop_ok && !w_in_flight) begin
              r_state <= S_IDLE;
              r_idle  <= 1'b1;
            end else begin
              r_idle  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign main_rd     = r_main_rd;
  assign vc0_wr      = r_wr0;
  assign vc1_wr      = r_wr1;
  assign vc_data_out = r_data;
  assign state       = r_state;
  assign idle        = r_idle;

`ifdef DISPATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counters move with the write strobes they count; init
  // holds them at zero, so late in-flight writes that land
  // during INIT are not counted.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_wr0_nxt && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_wr1_nxt && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign vc0_cnt = r_cnt0;
  assign vc1_cnt = r_cnt1;
`endif

endmodule
